// File: rtl/rgb_hue_pwm.sv
// RGB hue-sweep PWM engine: step timer -> hue register -> colour wheel -> brightness
// scale -> shadow duties -> period-aligned active duties driving active-low LED pins.
module rgb_hue_pwm #(
    parameter int CLK_FREQ    = 12000000,
    parameter int PWM_BITS    = 8,
    parameter int HUE_STEPS   = 360,
    parameter int STEP_CYCLES = 33333,
    localparam int HUE_BITS   = $clog2(HUE_STEPS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          mode,
    input  logic [HUE_BITS-1:0] hue_set,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [HUE_BITS-1:0] hue_out,
    output logic                period_start,
    output logic                RGB_R,
    output logic                RGB_G,
    output logic                RGB_B
);

    localparam int SEG      = HUE_STEPS / 3;
    localparam int MAX      = (1 << PWM_BITS) - 1;
    localparam int PROD_W   = PWM_BITS + HUE_BITS;
    localparam int TMR_BITS = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_FWD  = 2'b01;
    localparam logic [1:0] MODE_REV  = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    localparam logic [PWM_BITS-1:0] MAX_V     = PWM_BITS'(MAX);
    localparam logic [HUE_BITS-1:0] HUE_LAST  = HUE_BITS'(HUE_STEPS - 1);
    localparam logic [HUE_BITS-1:0] HUE_LIMIT = HUE_BITS'(HUE_STEPS);
    localparam logic [HUE_BITS-1:0] SEG_V     = HUE_BITS'(SEG);
    localparam logic [HUE_BITS-1:0] SEG2_V    = HUE_BITS'(2 * SEG);
    localparam logic [TMR_BITS-1:0] TMR_LAST  = TMR_BITS'(STEP_CYCLES - 1);

    if (HUE_STEPS < 3 || (HUE_STEPS % 3) != 0 || STEP_CYCLES < 1 || CLK_FREQ < 1) begin : g_bad_params
        $error("rgb_hue_pwm: invalid parameter set");
    end

    logic [TMR_BITS-1:0] timer;
    logic                step_tc;
    logic                sweeping;
    logic [HUE_BITS-1:0] hue_clamped;

    assign sweeping    = (mode == MODE_FWD) || (mode == MODE_REV);
    assign step_tc     = (timer == TMR_LAST);
    assign hue_clamped = (hue_set >= HUE_LIMIT) ? HUE_LAST : hue_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (!sweeping || step_tc) begin
            timer <= '0;
        end else begin
            timer <= timer + TMR_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hue_out <= '0;
        end else begin
            case (mode)
                MODE_FWD:  if (step_tc) hue_out <= (hue_out == HUE_LAST) ? '0 : hue_out + HUE_BITS'(1);
                MODE_REV:  if (step_tc) hue_out <= (hue_out == '0) ? HUE_LAST : hue_out - HUE_BITS'(1);
                MODE_HOLD: hue_out <= hue_clamped;
                default:   hue_out <= hue_out;
            endcase
        end
    end

    // Segment split by compare/subtract keeps the only true divide on a constant.
    logic [1:0]          seg;
    logic [HUE_BITS-1:0] ofs;
    logic [PROD_W-1:0]   rise_prod;
    logic [PWM_BITS-1:0] rise;
    logic [PWM_BITS-1:0] fall;
    logic [PWM_BITS-1:0] col_r_n, col_g_n, col_b_n;

    always_comb begin
        seg = 2'd0;
        ofs = hue_out;
        if (hue_out >= SEG2_V) begin
            seg = 2'd2;
            ofs = hue_out - SEG2_V;
        end else if (hue_out >= SEG_V) begin
            seg = 2'd1;
            ofs = hue_out - SEG_V;
        end
    end

    assign rise_prod = (PROD_W'(ofs) * PROD_W'(MAX)) / PROD_W'(SEG);
    assign rise      = PWM_BITS'(rise_prod);
    assign fall      = MAX_V - rise;

    always_comb begin
        col_r_n = '0;
        col_g_n = '0;
        col_b_n = '0;
        case (seg)
            2'd0: begin
                col_r_n = fall;
                col_g_n = rise;
            end
            2'd1: begin
                col_g_n = fall;
                col_b_n = rise;
            end
            default: begin
                col_r_n = rise;
                col_b_n = fall;
            end
        endcase
    end

    logic [PWM_BITS-1:0] col_r, col_g, col_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r <= '0;
            col_g <= '0;
            col_b <= '0;
        end else begin
            col_r <= col_r_n;
            col_g <= col_g_n;
            col_b <= col_b_n;
        end
    end

    // (brightness+1) scaling lets full-scale brightness pass the value untouched.
    function automatic logic [PWM_BITS-1:0] scale(input logic [PWM_BITS-1:0] v,
                                                  input logic [PWM_BITS-1:0] b);
        logic [2*PWM_BITS-1:0] p;
        p = (2*PWM_BITS)'(v) * ((2*PWM_BITS)'(b) + (2*PWM_BITS)'(1));
        return PWM_BITS'(p >> PWM_BITS);
    endfunction

    logic [PWM_BITS-1:0] shd_r, shd_g, shd_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shd_r <= '0;
            shd_g <= '0;
            shd_b <= '0;
        end else if (mode == MODE_OFF) begin
            shd_r <= '0;
            shd_g <= '0;
            shd_b <= '0;
        end else begin
            shd_r <= scale(col_r, brightness);
            shd_g <= scale(col_g, brightness);
            shd_b <= scale(col_b, brightness);
        end
    end

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] act_r, act_g, act_b;
    logic                wrap;

    assign wrap = (pwm_cnt == MAX_V);

    // Active duties only move at the wrap edge, so a period is never cut short.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt      <= '0;
            period_start <= 1'b0;
            act_r        <= '0;
            act_g        <= '0;
            act_b        <= '0;
        end else begin
            pwm_cnt      <= pwm_cnt + PWM_BITS'(1);
            period_start <= wrap;
            if (wrap) begin
                act_r <= shd_r;
                act_g <= shd_g;
                act_b <= shd_b;
            end
        end
    end

    assign RGB_R = !(pwm_cnt < act_r);
    assign RGB_G = !(pwm_cnt < act_g);
    assign RGB_B = !(pwm_cnt < act_b);

endmodule

// File: tb/tb_rgb_hue_pwm.sv
// Directed bench for rgb_hue_pwm with PWM_BITS=4, HUE_STEPS=12, STEP_CYCLES=4;
// duties are measured as low-cycle counts over one full PWM period.
module tb_rgb_hue_pwm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] mode;
    logic [3:0] hue_set;
    logic [3:0] brightness;
    logic [3:0] hue_out;
    logic       period_start;
    logic       RGB_R, RGB_G, RGB_B;

    int n_cmp = 0;
    int n_bad = 0;
    int on_r, on_g, on_b;
    bit found;
    int cyc;

    rgb_hue_pwm #(
        .PWM_BITS   (4),
        .HUE_STEPS  (12),
        .STEP_CYCLES(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode        (mode),
        .hue_set     (hue_set),
        .brightness  (brightness),
        .hue_out     (hue_out),
        .period_start(period_start),
        .RGB_R       (RGB_R),
        .RGB_G       (RGB_G),
        .RGB_B       (RGB_B)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_period(input string tag);
        found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (period_start) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_period_seen"}, int'(found), 1);
    endtask

    // Counts low cycles over the next full period, starting at its period_start sample.
    task automatic measure(input string tag, input int er, input int eg, input int eb);
        wait_period(tag);
        on_r = 0; on_g = 0; on_b = 0;
        for (int i = 0; i < 16; i++) begin
            on_r += int'(!RGB_R);
            on_g += int'(!RGB_G);
            on_b += int'(!RGB_B);
            @(negedge clk);
        end
        check({tag, "_R"}, on_r, er);
        check({tag, "_G"}, on_g, eg);
        check({tag, "_B"}, on_b, eb);
    endtask

    task automatic cycles_to_period(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (period_start) break;
        end
    endtask

    initial begin
        rst_n = 1'b0; mode = 2'b00; hue_set = 4'd0; brightness = 4'd15;
        repeat (3) @(negedge clk);
        check("rst_R", int'(RGB_R), 1);
        check("rst_G", int'(RGB_G), 1);
        check("rst_B", int'(RGB_B), 1);
        check("rst_hue", int'(hue_out), 0);
        check("rst_pstart", int'(period_start), 0);
        rst_n = 1'b1;
        cycles_to_period(cyc);
        check("rst_first_pstart", cyc, 16);

        mode = 2'b01;
        for (int i = 0; i < 12; i++) begin
            repeat (3) @(negedge clk);
            check("fwd_hold_between_steps", int'(hue_out), i);
            @(negedge clk);
            check("fwd_step", int'(hue_out), (i + 1) % 12);
        end

        mode = 2'b10;
        repeat (4) @(negedge clk);
        check("rev_wrap", int'(hue_out), 11);
        repeat (4) @(negedge clk);
        check("rev_step", int'(hue_out), 10);
        repeat (2) @(negedge clk);
        mode = 2'b01;
        @(negedge clk);
        check("dir_switch_no_step", int'(hue_out), 10);
        @(negedge clk);
        check("dir_switch_keeps_phase", int'(hue_out), 11);

        mode = 2'b11; hue_set = 4'd1;
        repeat (40) @(negedge clk);
        measure("hue1_full", 12, 3, 0);

        hue_set = 4'd15;
        @(negedge clk);
        check("hold_clamp", int'(hue_out), 11);
        hue_set = 4'd4;
        repeat (40) @(negedge clk);
        measure("hue4_full", 0, 15, 0);

        hue_set = 4'd1; brightness = 4'd7;
        repeat (40) @(negedge clk);
        measure("hue1_b7", 6, 1, 0);
        brightness = 4'd0;
        repeat (40) @(negedge clk);
        measure("hue1_b0", 0, 0, 0);
        brightness = 4'd15;

        // Mid-period hue change: current period keeps old duty, next period has new.
        hue_set = 4'd1;
        repeat (40) @(negedge clk);
        wait_period("glitch");
        on_r = 0; on_g = 0; on_b = 0; cyc = 0;
        for (int i = 0; i < 16; i++) begin
            on_r += int'(!RGB_R);
            on_g += int'(!RGB_G);
            on_b += int'(!RGB_B);
            if (i == 2) hue_set = 4'd4;
            @(negedge clk);
            if (i >= 2) cyc++;
        end
        check("glitch_old_R", on_r, 12);
        check("glitch_old_G", on_g, 3);
        check("glitch_old_B", on_b, 0);
        check("glitch_boundary_pstart", int'(period_start), 1);
        check("glitch_latency", cyc, 14);
        measure("glitch_new", 0, 15, 0);

        mode = 2'b00;
        repeat (20) @(negedge clk);
        check("off_hue_frozen", int'(hue_out), 4);
        measure("off", 0, 0, 0);

        mode = 2'b11; hue_set = 4'd4;
        repeat (40) @(negedge clk);
        wait_period("midrst");
        repeat (3) @(negedge clk);
        check("midrst_G_before", int'(RGB_G), 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_R", int'(RGB_R), 1);
        check("midrst_G", int'(RGB_G), 1);
        check("midrst_B", int'(RGB_B), 1);
        check("midrst_hue", int'(hue_out), 0);
        check("midrst_pstart", int'(period_start), 0);
        mode = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        cycles_to_period(cyc);
        check("midrst_first_pstart", cyc, 16);
        check("midrst_hue_after", int'(hue_out), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
